// File: rtl/regfile_sb.sv
// Integer register file with an issue scoreboard.
// Two combinational read ports with write-back bypass, RAW/WAW issue gating,
// a sticky halt flag for the simulation-exit sentinel and a sticky error flag
// for write-backs that arrive at registers with no pending write.
module regfile_sb #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter int              AW       = $clog2(NREG),
    parameter int              SP_IDX   = 2,
    parameter logic [XLEN-1:0] SP_RESET = 32'h12000,
    parameter int              HALT_IDX = 31,
    parameter logic [XLEN-1:0] HALT_VAL = 32'hDEAD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iss_valid_i,
    output logic            iss_ready_o,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    input  logic [AW-1:0]   rd_i,
    input  logic            rd_we_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [NREG-1:0] busy_o,
    output logic            halt_o,
    output logic            err_o
);

    localparam logic [AW-1:0] HALT_IDX_C = HALT_IDX[AW-1:0];

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            halt_q;
    logic            halt_d;
    logic            err_q;
    logic            err_d;

    logic            wb_en_s;
    logic            haz1_s;
    logic            haz2_s;
    logic            hazd_s;
    logic            ready_s;
    logic            fire_s;
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;

    // Source operand reads: index 0 is hard zero, a same-cycle write-back wins over the array.
    always_comb begin
        rs1_data_s = {XLEN{1'b0}};
        rs2_data_s = {XLEN{1'b0}};
        if (rs1_i == {AW{1'b0}}) begin
            rs1_data_s = {XLEN{1'b0}};
        end else if (wb_valid_i && (wb_rd_i == rs1_i)) begin
            rs1_data_s = wb_data_i;
        end else begin
            rs1_data_s = regs_q[rs1_i];
        end
        if (rs2_i == {AW{1'b0}}) begin
            rs2_data_s = {XLEN{1'b0}};
        end else if (wb_valid_i && (wb_rd_i == rs2_i)) begin
            rs2_data_s = wb_data_i;
        end else begin
            rs2_data_s = regs_q[rs2_i];
        end
    end

    // Hazard detection: a pending register is not a hazard if its result arrives this cycle.
    always_comb begin
        haz1_s  = busy_q[rs1_i] && !(wb_valid_i && (wb_rd_i == rs1_i));
        haz2_s  = busy_q[rs2_i] && !(wb_valid_i && (wb_rd_i == rs2_i));
        hazd_s  = rd_we_i && busy_q[rd_i] && !(wb_valid_i && (wb_rd_i == rd_i));
        ready_s = !haz1_s && !haz2_s && !hazd_s;
        fire_s  = iss_valid_i && ready_s;
        wb_en_s = wb_valid_i && (wb_rd_i != {AW{1'b0}});
    end

    // Next state: write-back clears busy, issue sets it afterwards so set wins on the same index.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        busy_d = busy_q;
        halt_d = halt_q;
        err_d  = err_q;
        if (wb_en_s) begin
            regs_d[wb_rd_i] = wb_data_i;
            busy_d[wb_rd_i] = 1'b0;
            if (!busy_q[wb_rd_i]) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if ((wb_rd_i == HALT_IDX_C) && (wb_data_i == HALT_VAL)) begin
                halt_d = 1'b1;
            end else begin
                halt_d = halt_q;
            end
        end else begin
            busy_d = busy_q;
        end
        if (fire_s && rd_we_i && (rd_i != {AW{1'b0}})) begin
            busy_d[rd_i] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
    end

    // State registers with synchronous active-low reset; write-backs in a reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            regs_q[SP_IDX] <= SP_RESET;
            busy_q         <= {NREG{1'b0}};
            halt_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
            halt_q <= halt_d;
            err_q  <= err_d;
        end
    end

    assign iss_ready_o = ready_s;
    assign rs1_data_o  = rs1_data_s;
    assign rs2_data_o  = rs2_data_s;
    assign busy_o      = busy_q;
    assign halt_o      = halt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a table of per-cycle stimulus and expected
// outputs applied in order, followed by hand-written reset sequences.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic        iss_valid_i;
    logic        iss_ready_o;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [4:0]  rd_i;
    logic        rd_we_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic [31:0] busy_o;
    logic        halt_o;
    logic        err_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        iss_valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        wb_valid;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        exp_ready;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
        logic [31:0] exp_busy;
        logic        exp_halt;
        logic        exp_err;
    } vec_t;

    vec_t vecs [22];

    regfile_sb dut (
        .clk         (clk),
        .reset       (reset),
        .iss_valid_i (iss_valid_i),
        .iss_ready_o (iss_ready_o),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rd_i        (rd_i),
        .rd_we_i     (rd_we_i),
        .rs1_data_o  (rs1_data_o),
        .rs2_data_o  (rs2_data_o),
        .wb_valid_i  (wb_valid_i),
        .wb_rd_i     (wb_rd_i),
        .wb_data_i   (wb_data_i),
        .busy_o      (busy_o),
        .halt_o      (halt_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iss_valid_i = 1'b0;
        rs1_i       = 5'd0;
        rs2_i       = 5'd0;
        rd_i        = 5'd0;
        rd_we_i     = 1'b0;
        wb_valid_i  = 1'b0;
        wb_rd_i     = 5'd0;
        wb_data_i   = 32'h0;
    endtask

    initial begin
        // iss  rs1    rs2    rd     we    wbv   wbrd   wbdata        rdy   rs1data        rs2data        busy           halt  err
        vecs[0]  = '{1'b0, 5'd2,  5'd1,  5'd0, 1'b0, 1'b0, 5'd0,  32'h0,      1'b1, 32'h00012000, 32'h0,      32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  5'd0,  5'd5, 1'b1, 1'b0, 5'd0,  32'h0,      1'b1, 32'h0,        32'h0,      32'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd5,  5'd0,  5'd6, 1'b1, 1'b0, 5'd0,  32'h0,      1'b0, 32'h0,        32'h0,      32'h00000020, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd5,  5'd0,  5'd6, 1'b1, 1'b1, 5'd5,  32'h1234,   1'b1, 32'h1234,     32'h0,      32'h00000020, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd5,  5'd6,  5'd0, 1'b0, 1'b0, 5'd0,  32'h0,      1'b0, 32'h1234,     32'h0,      32'h00000040, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd0,  5'd0,  5'd6, 1'b1, 1'b0, 5'd0,  32'h0,      1'b0, 32'h0,        32'h0,      32'h00000040, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'd0,  5'd0,  5'd6, 1'b0, 1'b0, 5'd0,  32'h0,      1'b1, 32'h0,        32'h0,      32'h00000040, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  5'd6,  5'd0, 1'b0, 1'b1, 5'd6,  32'hAA,     1'b1, 32'h0,        32'hAA,     32'h00000040, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  5'd6,  5'd0, 1'b0, 1'b1, 5'd0,  32'hFFFF,   1'b1, 32'h0,        32'hAA,     32'h0,        1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 5'd0,  32'h0,      1'b1, 32'h0,        32'h0,      32'h0,        1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd0,  5'd0,  5'd7, 1'b1, 1'b0, 5'd0,  32'h0,      1'b1, 32'h0,        32'h0,      32'h0,        1'b0, 1'b0};
        vecs[11] = '{1'b1, 5'd7,  5'd0,  5'd7, 1'b1, 1'b1, 5'd7,  32'h9,      1'b1, 32'h9,        32'h0,      32'h00000080, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd7,  5'd0,  5'd0, 1'b0, 1'b1, 5'd7,  32'h9,      1'b1, 32'h9,        32'h0,      32'h00000080, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 5'd7,  5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  32'h0,      1'b1, 32'h9,        32'h0,      32'h0,        1'b0, 1'b0};
        vecs[14] = '{1'b0, 5'd3,  5'd0,  5'd0, 1'b0, 1'b1, 5'd3,  32'h33,     1'b1, 32'h33,       32'h0,      32'h0,        1'b0, 1'b0};
        vecs[15] = '{1'b0, 5'd3,  5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  32'h0,      1'b1, 32'h33,       32'h0,      32'h0,        1'b0, 1'b1};
        vecs[16] = '{1'b0, 5'd0,  5'd3,  5'd0, 1'b0, 1'b0, 5'd0,  32'h0,      1'b1, 32'h0,        32'h33,     32'h0,        1'b0, 1'b1};
        vecs[17] = '{1'b0, 5'd31, 5'd0,  5'd0, 1'b0, 1'b1, 5'd31, 32'hDEAD,   1'b1, 32'hDEAD,     32'h0,      32'h0,        1'b0, 1'b1};
        vecs[18] = '{1'b0, 5'd31, 5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  32'h0,      1'b1, 32'hDEAD,     32'h0,      32'h0,        1'b1, 1'b1};
        vecs[19] = '{1'b1, 5'd0,  5'd0,  5'd4, 1'b1, 1'b0, 5'd0,  32'h0,      1'b1, 32'h0,        32'h0,      32'h0,        1'b1, 1'b1};
        vecs[20] = '{1'b0, 5'd4,  5'd0,  5'd0, 1'b0, 1'b1, 5'd4,  32'h44,     1'b1, 32'h44,       32'h0,      32'h00000010, 1'b1, 1'b1};
        vecs[21] = '{1'b1, 5'd4,  5'd0,  5'd4, 1'b1, 1'b0, 5'd0,  32'h0,      1'b1, 32'h44,       32'h0,      32'h0,        1'b1, 1'b1};

        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            iss_valid_i = vecs[i].iss_valid;
            rs1_i       = vecs[i].rs1;
            rs2_i       = vecs[i].rs2;
            rd_i        = vecs[i].rd;
            rd_we_i     = vecs[i].rd_we;
            wb_valid_i  = vecs[i].wb_valid;
            wb_rd_i     = vecs[i].wb_rd;
            wb_data_i   = vecs[i].wb_data;
            #1;
            check($sformatf("vec%0d.ready", i), {31'h0, iss_ready_o}, {31'h0, vecs[i].exp_ready});
            check($sformatf("vec%0d.rs1",   i), rs1_data_o,           vecs[i].exp_rs1);
            check($sformatf("vec%0d.rs2",   i), rs2_data_o,           vecs[i].exp_rs2);
            check($sformatf("vec%0d.busy",  i), busy_o,               vecs[i].exp_busy);
            check($sformatf("vec%0d.halt",  i), {31'h0, halt_o},      {31'h0, vecs[i].exp_halt});
            check($sformatf("vec%0d.err",   i), {31'h0, err_o},       {31'h0, vecs[i].exp_err});
            @(negedge clk);
        end

        // r4 pending, halt and err set: reset with a write-back to r4 in the same cycle.
        idle_inputs();
        reset      = 1'b0;
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd4;
        wb_data_i  = 32'h55;
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        rs1_i = 5'd4;
        rs2_i = 5'd2;
        #1;
        check("rst.halt",  {31'h0, halt_o},      32'h0);
        check("rst.err",   {31'h0, err_o},       32'h0);
        check("rst.busy",  busy_o,               32'h0);
        check("rst.r4",    rs1_data_o,           32'h0);
        check("rst.sp",    rs2_data_o,           32'h00012000);
        check("rst.ready", {31'h0, iss_ready_o}, 32'h1);

        // Wrong value to the halt register must not raise halt.
        @(negedge clk);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd31;
        wb_data_i  = 32'hBEEF;
        @(negedge clk);
        idle_inputs();
        rs1_i = 5'd31;
        #1;
        check("nohalt.halt", {31'h0, halt_o}, 32'h0);
        check("nohalt.r31",  rs1_data_o,      32'hBEEF);
        check("nohalt.err",  {31'h0, err_o},  32'h1);

        // Sentinel to a register other than the halt index must not raise halt.
        @(negedge clk);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd30;
        wb_data_i  = 32'hDEAD;
        @(negedge clk);
        idle_inputs();
        #1;
        check("nohalt30.halt", {31'h0, halt_o}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
